// File: rtl/pool_writeback_pkg.sv
// Shared types and widths for the pool writeback stage.
package pool_writeback_pkg;

   localparam int DWIDTH    = 16;
   localparam int LWIDTH    = 10;
   localparam int PSIZE     = 2;
   localparam int AWIDTH_DF = 12;
   localparam int PHW       = (PSIZE > 1) ? $clog2(PSIZE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } pool_wb_state_t;

endpackage

// File: rtl/pool_writeback_if.sv
// Control, pixel-stream and memory-write bundle of the pool writeback stage.
interface pool_writeback_if #(
   parameter int AWIDTH = 12
);
   import pool_writeback_pkg::*;

   logic              start;
   logic [LWIDTH-1:0] w_fea_size;
   logic [LWIDTH-1:0] w_pool_size;
   logic [LWIDTH-1:0] w_out_size;
   logic [AWIDTH-1:0] w_out_base;
   logic              pix_valid;
   logic [DWIDTH-1:0] pix_in;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_wdata;
   logic              busy;
   logic              done;

   modport master (
      output start, w_fea_size, w_pool_size, w_out_size, w_out_base,
      output pix_valid, pix_in,
      input  mem_we, mem_addr, mem_wdata, busy, done
   );

   modport slave (
      input  start, w_fea_size, w_pool_size, w_out_size, w_out_base,
      input  pix_valid, pix_in,
      output mem_we, mem_addr, mem_wdata, busy, done
   );

endinterface

// File: rtl/pool_writeback_cnt.sv
// Window-position tracker: raster col/row over N-P+1 positions plus pool phase.
module pool_wb_cnt
   import pool_writeback_pkg::*;
(
   input  logic              clk,
   input  logic              xrst,
   input  logic              clr_i,
   input  logic              adv_i,
   input  logic [LWIDTH-1:0] fea_size_i,
   input  logic [LWIDTH-1:0] pool_size_i,
   input  logic [LWIDTH-1:0] out_size_i,
   output logic              keep_o,
   output logic              last_pos_o
);

   logic [LWIDTH-1:0] col_q, row_q, span_q, lim_q;
   logic [PHW-1:0]    cph_q, rph_q, pm1_q;

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         col_q  <= '0;
         row_q  <= '0;
         cph_q  <= '0;
         rph_q  <= '0;
         span_q <= '0;
         lim_q  <= '0;
         pm1_q  <= '0;
      end else if (clr_i) begin
         col_q  <= '0;
         row_q  <= '0;
         cph_q  <= '0;
         rph_q  <= '0;
         span_q <= fea_size_i - pool_size_i;
         lim_q  <= out_size_i * pool_size_i;
         pm1_q  <= PHW'(pool_size_i - LWIDTH'(1));
      end else if (adv_i) begin
         if (col_q == span_q) begin
            col_q <= '0;
            cph_q <= '0;
            if (row_q == span_q) begin
               row_q <= '0;
               rph_q <= '0;
            end else begin
               row_q <= row_q + LWIDTH'(1);
               rph_q <= (rph_q == pm1_q) ? '0 : rph_q + PHW'(1);
            end
         end else begin
            col_q <= col_q + LWIDTH'(1);
            cph_q <= (cph_q == pm1_q) ? '0 : cph_q + PHW'(1);
         end
      end
   end

   // Trailing partial windows (N mod P) fall outside M*P and are dropped.
   assign keep_o     = (cph_q == '0) && (rph_q == '0) && (col_q < lim_q) && (row_q < lim_q);
   assign last_pos_o = (col_q == span_q) && (row_q == span_q);

endmodule

// File: rtl/pool_writeback.sv
// Writes stride-aligned max-pool results as a dense M x M map, then pulses done.
// Optional fused ReLU on written data: define POOL_WB_RELU_EN.
module pool_writeback
   import pool_writeback_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DF
) (
   input logic            clk,
   input logic            xrst,
   pool_writeback_if.slave bus
);

   pool_wb_state_t    state_q;
   logic [LWIDTH-1:0] m_q, ocol_q, orow_q;
   logic [AWIDTH-1:0] base_q, rbase_q, addr_q;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic              fin_q, we_q, busy_q, done_q;
   logic              launch, adv, keep, last_pos, take, col_end, last_kept;

   assign launch    = (state_q == S_IDLE) && bus.start;
   assign adv       = (state_q == S_RUN) && bus.pix_valid;
   assign take      = adv && keep && !fin_q;
   assign col_end   = (ocol_q + LWIDTH'(1)) == m_q;
   assign last_kept = col_end && ((orow_q + LWIDTH'(1)) == m_q);

   always_comb begin
      wdata_d = bus.pix_in;
`ifdef POOL_WB_RELU_EN
      if (bus.pix_in[DWIDTH-1]) wdata_d = '0;
`endif
   end

   pool_wb_cnt u_cnt (
      .clk        (clk),
      .xrst       (xrst),
      .clr_i      (launch),
      .adv_i      (adv),
      .fea_size_i (bus.w_fea_size),
      .pool_size_i(bus.w_pool_size),
      .out_size_i (bus.w_out_size),
      .keep_o     (keep),
      .last_pos_o (last_pos)
   );

   // fin_q marks "no more writes": set by the M*M-th keep (or M=0 at start);
   // later pixels in RUN are consumed silently and RUN exits next cycle.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         ocol_q  <= '0;
         orow_q  <= '0;
         base_q  <= '0;
         rbase_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fin_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  m_q     <= bus.w_out_size;
                  base_q  <= bus.w_out_base;
                  ocol_q  <= '0;
                  orow_q  <= '0;
                  rbase_q <= '0;
                  fin_q   <= (bus.w_out_size == '0);
               end
            end
            S_RUN: begin
               if (fin_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
               if (take) begin
                  we_q    <= 1'b1;
                  addr_q  <= base_q + rbase_q + AWIDTH'(ocol_q);
                  wdata_q <= wdata_d;
                  if (col_end) begin
                     ocol_q  <= '0;
                     orow_q  <= orow_q + LWIDTH'(1);
                     rbase_q <= rbase_q + AWIDTH'(m_q);
                  end else begin
                     ocol_q <= ocol_q + LWIDTH'(1);
                  end
                  if (last_kept) fin_q <= 1'b1;
               end
               if (adv && last_pos) fin_q <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
